dmem_arbiter: RTL and testbench

Arbiter and fill sequencer in front of the single-port data memory (combinational read, write on rising clock edge, one address pointer shared by reads and writes). It shares the memory between two requesters, A (core load/store) and B (auxiliary/debug port), using round-robin priority. It also has a built-in fill engine that writes a constant over an address range, so the team can clear or preload memory without the memory's own reset preload. It sits between the requesters and the memory, and owns the memory's write-enable, address and write-data inputs exclusively.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter between requesters A and B in front of a
// single-port data memory, plus a fill engine that writes a constant over an
// address range (wrapping modulo 2**D).
// Ports: clk_i/rst_i (async active-high); a_*/b_* requester ports with zero-latency
// grant and same-cycle read data; fill_* control/status; mem_* to the memory.
module dmem_arbiter #(
  parameter int W = 8,
  parameter int D = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         a_req_i,
  input  logic         a_we_i,
  input  logic [D-1:0] a_addr_i,
  input  logic [W-1:0] a_wdata_i,
  output logic         a_gnt_o,
  output logic [W-1:0] a_rdata_o,
  input  logic         b_req_i,
  input  logic         b_we_i,
  input  logic [D-1:0] b_addr_i,
  input  logic [W-1:0] b_wdata_i,
  output logic         b_gnt_o,
  output logic [W-1:0] b_rdata_o,
  input  logic         fill_start_i,
  input  logic [D-1:0] fill_base_i,
  input  logic [D-1:0] fill_count_i,
  input  logic [W-1:0] fill_value_i,
  output logic         fill_busy_o,
  output logic         fill_done_o,
  output logic         mem_we_o,
  output logic [D-1:0] mem_addr_o,
  output logic [W-1:0] mem_wdata_o,
  input  logic [W-1:0] mem_rdata_i
);

  typedef enum logic {ST_IDLE, ST_FILL} state_e;

  localparam logic [D-1:0] ONE = D'(1);

  state_e       state_q, state_d;
  logic         last_b_q, last_b_d;
  logic [D-1:0] idx_q, idx_d;
  logic [D-1:0] base_q, base_d;
  logic [D-1:0] cnt_q, cnt_d;
  logic [W-1:0] val_q, val_d;
  logic         done_q, done_d;
  logic [D-1:0] addr_q, addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [D-1:0] last_idx;
  logic         gnt_a, gnt_b;

  // A count of 0 means 2**D words; subtracting one in D bits maps it to 2**D-1.
  assign last_idx = cnt_q - ONE;

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    idx_d    = idx_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    val_d    = val_q;
    done_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    mem_we_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Grants are combinational, so gate them while reset is held to keep
        // the memory quiet even if requesters are already active.
        if (!rst_i) begin
          if (a_req_i && b_req_i) begin
            gnt_a = last_b_q;
            gnt_b = ~last_b_q;
          end else begin
            gnt_a = a_req_i;
            gnt_b = b_req_i;
          end

          if (gnt_a) begin
            mem_we_o = a_we_i;
            addr_d   = a_addr_i;
            wdata_d  = a_wdata_i;
            last_b_d = 1'b0;
          end else if (gnt_b) begin
            mem_we_o = b_we_i;
            addr_d   = b_addr_i;
            wdata_d  = b_wdata_i;
            last_b_d = 1'b1;
          end

          if (fill_start_i) begin
            base_d  = fill_base_i;
            cnt_d   = fill_count_i;
            val_d   = fill_value_i;
            idx_d   = '0;
            state_d = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        mem_we_o = 1'b1;
        addr_d   = base_q + idx_q;
        wdata_d  = val_q;
        idx_d    = idx_q + ONE;
        if (idx_q == last_idx) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Address/data go straight out from the next-state value; the registered copy
  // only exists so idle cycles repeat the last driven value instead of X.
  assign mem_addr_o  = addr_d;
  assign mem_wdata_o = wdata_d;
  assign a_gnt_o     = gnt_a;
  assign b_gnt_o     = gnt_b;
  assign a_rdata_o   = mem_rdata_i;
  assign b_rdata_o   = mem_rdata_i;
  assign fill_busy_o = (state_q == ST_FILL);
  assign fill_done_o = done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      last_b_q <= 1'b1;
      idx_q    <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      val_q    <= '0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic, with a
// queue-based scoreboard fed by a transaction-level reference model and drained
// by a monitor that fires whenever the DUT shows activity.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, b_gnt;
  logic [7:0] a_rdata, b_rdata;
  logic       fill_start;
  logic [7:0] fill_base, fill_count, fill_value;
  logic       fill_busy, fill_done;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  dmem_arbiter #(.W(8), .D(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rdata_o(b_rdata),
    .fill_start_i(fill_start), .fill_base_i(fill_base), .fill_count_i(fill_count),
    .fill_value_i(fill_value), .fill_busy_o(fill_busy), .fill_done_o(fill_done),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    bit         ga;
    bit         gb;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    bit         busy;
    bit         done;
  } exp_t;

  exp_t       sb [$];
  int         checks = 0;
  int         passes = 0;

  // Reference model: memory image, round-robin memory of who won last, and the
  // list of addresses a running fill still has to write.
  logic [7:0] ref_mem [256];
  bit         m_last_b;
  logic [7:0] fill_q [$];
  logic [7:0] m_fill_val;
  bit         m_done_pending;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, got, want);
  endtask

  task automatic monitor();
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (!rst && (a_gnt || b_gnt || mem_we || fill_busy || fill_done)) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_activity: gA=%0d gB=%0d we=%0d addr=%02h busy=%0d done=%0d, required no activity",
                   a_gnt, b_gnt, mem_we, mem_addr, fill_busy, fill_done);
        end else begin
          e  = sb.pop_front();
          ok = (a_gnt === e.ga) && (b_gnt === e.gb) && (mem_we === e.we) &&
               (fill_busy === e.busy) && (fill_done === e.done);
          if ((e.ga || e.gb || e.we) && mem_addr !== e.addr) ok = 0;
          if (e.we && mem_wdata !== e.wdata) ok = 0;
          if (e.ga && !e.we && a_rdata !== e.rdata) ok = 0;
          if (e.gb && !e.we && b_rdata !== e.rdata) ok = 0;
          if (ok) passes++;
          else $display("FAIL sb_event: got gA=%0d gB=%0d we=%0d addr=%02h wd=%02h rdA=%02h rdB=%02h busy=%0d done=%0d; required gA=%0d gB=%0d we=%0d addr=%02h wd=%02h rd=%02h busy=%0d done=%0d",
                        a_gnt, b_gnt, mem_we, mem_addr, mem_wdata, a_rdata, b_rdata, fill_busy, fill_done,
                        e.ga, e.gb, e.we, e.addr, e.wdata, e.rdata, e.busy, e.done);
        end
      end
    end
  endtask

  // One clock cycle: predict what the DUT should do with the inputs currently
  // applied, queue it if observable, then advance the model past the edge.
  task automatic step();
    exp_t e;
    bit   fill_cyc;
    int   n;
    e = '{default: '0};
    fill_cyc = (fill_q.size() != 0);
    if (fill_cyc) begin
      e.we = 1; e.busy = 1; e.addr = fill_q[0]; e.wdata = m_fill_val;
    end else begin
      e.done = m_done_pending;
      if (a_req && (!b_req || m_last_b)) begin
        e.ga = 1; e.we = a_we; e.addr = a_addr; e.wdata = a_wdata;
      end else if (b_req) begin
        e.gb = 1; e.we = b_we; e.addr = b_addr; e.wdata = b_wdata;
      end
      if ((e.ga || e.gb) && !e.we) e.rdata = ref_mem[e.addr];
    end
    if (e.ga || e.gb || e.we || e.done) sb.push_back(e);
    @(posedge clk);
    #1;
    m_done_pending = 0;
    if (fill_cyc) begin
      ref_mem[e.addr] = e.wdata;
      void'(fill_q.pop_front());
      m_done_pending = (fill_q.size() == 0);
    end else begin
      if (e.we) ref_mem[e.addr] = e.wdata;
      if (e.ga) begin m_last_b = 0; a_req = 0; end
      if (e.gb) begin m_last_b = 1; b_req = 0; end
      if (fill_start) begin
        n = (fill_count == 0) ? 256 : int'(fill_count);
        for (int i = 0; i < n; i++) fill_q.push_back(8'(int'(fill_base) + i));
        m_fill_val = fill_value;
      end
    end
  endtask

  task automatic access(bit is_b, bit we, logic [7:0] addr, logic [7:0] data);
    int tries = 0;
    if (is_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
    while ((is_b ? b_req : a_req) && tries < 4) begin step(); tries++; end
    if (is_b ? b_req : a_req) begin
      checks++;
      $display("FAIL access_timeout: requester %0d not granted within %0d cycles, required grant", is_b, tries);
      a_req = 0; b_req = 0;
    end
  endtask

  task automatic do_fill(logic [7:0] base, logic [7:0] cnt, logic [7:0] val);
    fill_base = base; fill_count = cnt; fill_value = val; fill_start = 1;
    step();
    fill_start = 0;
    for (int k = 0; k < 300 && fill_q.size() != 0; k++) step();
    step();
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_a_gnt"}, a_gnt, 0);
    chk({tag, "_b_gnt"}, b_gnt, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_busy"}, fill_busy, 0);
    chk({tag, "_done"}, fill_done, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fork monitor(); join_none

    // Reset with every input active: nothing may leak out.
    rst = 1; a_req = 1; a_we = 1; a_addr = 8'h33; a_wdata = 8'h44;
    b_req = 1; b_we = 1; b_addr = 8'h55; b_wdata = 8'h66;
    fill_start = 1; fill_base = 8'h10; fill_count = 8'h3; fill_value = 8'h77;
    m_last_b = 1; m_done_pending = 0;
    #12;
    reset_checks("por");
    @(posedge clk); #1;
    rst = 0; a_req = 0; b_req = 0; fill_start = 0;

    // Contention straight after reset: A, B, A, B.
    for (int i = 0; i < 4; i++) begin
      a_req = 1; a_we = 1; a_addr = 8'h21; a_wdata = 8'(8'hA0 + i);
      b_req = 1; b_we = 1; b_addr = 8'h22; b_wdata = 8'(8'hB0 + i);
      step();
    end
    a_req = 0; b_req = 0;

    // Single A write then read-back.
    access(0, 1, 8'h10, 8'h5A);
    access(0, 0, 8'h10, 8'h00);
    access(1, 0, 8'h21, 8'h00);

    // Wrapping fill with both requesters waiting throughout.
    a_req = 1; a_we = 0; a_addr = 8'h10;
    b_req = 1; b_we = 0; b_addr = 8'h22;
    do_fill(8'hFE, 8'd4, 8'h00);
    for (int k = 0; k < 3 && (a_req || b_req); k++) step();

    // Full-depth fill, then read every address back.
    do_fill(8'h05, 8'd0, 8'hAA);
    for (int ad = 0; ad < 256; ad++) access(1, 0, 8'(ad), 8'h00);

    // Second start while busy must be ignored.
    fill_base = 8'h50; fill_count = 8'd5; fill_value = 8'h77; fill_start = 1;
    step();
    fill_start = 0;
    step();
    fill_base = 8'h60; fill_count = 8'd3; fill_value = 8'h99; fill_start = 1;
    step();
    fill_start = 0;
    for (int k = 0; k < 20 && fill_q.size() != 0; k++) step();
    step();
    for (int ad = 8'h50; ad < 8'h64; ad++) access(0, 0, 8'(ad), 8'h00);

    // Reset while the third word of an 8-word fill is being written.
    fill_base = 8'h80; fill_count = 8'd8; fill_value = 8'h33; fill_start = 1;
    step();
    fill_start = 0;
    step();
    step();
    rst = 1; a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    fill_q.delete(); m_done_pending = 0; m_last_b = 1;
    #1;
    reset_checks("midfill");
    @(posedge clk); @(posedge clk); #1;
    rst = 0; a_req = 0; b_req = 0;
    step();
    for (int ad = 8'h80; ad < 8'h88; ad++) access(0, 0, 8'(ad), 8'h00);

    // Random traffic with occasional (sometimes overlapping) fills.
    for (int c = 0; c < 600; c++) begin
      if (!a_req && $urandom_range(0, 2) != 0) begin
        a_req = 1; a_we = 1'($urandom); a_addr = 8'($urandom_range(0, 31)); a_wdata = 8'($urandom);
      end
      if (!b_req && $urandom_range(0, 2) != 0) begin
        b_req = 1; b_we = 1'($urandom); b_addr = 8'($urandom_range(0, 31)); b_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 40) == 0) begin
        fill_start = 1; fill_base = 8'($urandom_range(0, 40));
        fill_count = 8'($urandom_range(1, 6)); fill_value = 8'($urandom);
      end
      step();
      fill_start = 0;
    end
    a_req = 0; b_req = 0;
    for (int k = 0; k < 10; k++) step();
    for (int ad = 0; ad < 48; ad++) access(1, 0, 8'(ad), 8'h00);
    step();

    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
